imem_stream_loader: RTL and testbench

- Hardware program loader for the RV64I core's instruction memory; the in-system counterpart of the bench's hex preload.
- Accepts a byte stream (UART/debug bridge side), assembles little-endian 32-bit instructions and writes them to the imem write port.
- Holds the core in reset while loading, then for a fixed post-load interval, then releases it.
- Sits between the boot byte source and core.clk/core.rst plus the imem write port.

---
 rtl/imem_stream_loader_pkg.sv | 16 +
 rtl/imem_stream_loader_if.sv | 27 ++
 rtl/imem_stream_loader_byte_packer.sv | 47 ++++
 rtl/imem_stream_loader.sv | 172 +++++++++++++++++
 tb/tb_imem_stream_loader.sv | 284 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/imem_stream_loader_pkg.sv
// Shared types and constants for the instruction-memory stream loader.
package imem_loader_pkg;

    localparam int HDR_BYTES = 4;   // bytes per little-endian field (length, word, checksum)
    localparam int INSTR_W   = 32;  // instruction word width

    typedef enum logic [2:0] {
        S_LEN,
        S_LOAD,
        S_CSUM,
        S_HOLD,
        S_RUN,
        S_ERR
    } loader_state_t;

endpackage

// File: rtl/imem_stream_loader_if.sv
// Byte-stream input, imem write port and core control bundled for the loader.
// master: boot byte source / environment side.  slave: the loader itself.
interface imem_stream_loader_if
    import imem_loader_pkg::*;
#(
    parameter int ADDR_W = 10
);
    logic [7:0]         in_data;
    logic               in_valid;
    logic               in_ready;
    logic               imem_we;
    logic [ADDR_W-1:0]  imem_addr;
    logic [INSTR_W-1:0] imem_wdata;
    logic               core_rst;
    logic               done;
    logic               err;

    modport master (
        output in_data, in_valid,
        input  in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
    );

    modport slave (
        input  in_data, in_valid,
        output in_ready, imem_we, imem_addr, imem_wdata, core_rst, done, err
    );
endinterface

// File: rtl/imem_stream_loader_byte_packer.sv
// Assembles four accepted bytes into a little-endian word {b3,b2,b1,b0}.
// word_valid pulses combinationally on the cycle the 4th byte is accepted;
// only the first three bytes need storing since the 4th is on byte_data.
module byte_packer
    import imem_loader_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    output logic               word_valid,
    output logic [INSTR_W-1:0] word
);
    localparam int CNT_W = $clog2(HDR_BYTES);
    localparam int SH_W  = INSTR_W - 8;

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [SH_W-1:0]  shift_q, shift_d;

    // Next byte count and shift contents; newest byte enters at the top.
    always_comb begin
        cnt_d   = cnt_q;
        shift_d = shift_q;
        if (clr) begin
            cnt_d   = '0;
            shift_d = '0;
        end else if (byte_valid) begin
            cnt_d   = cnt_q + CNT_W'(1);
            shift_d = {byte_data, shift_q[SH_W-1:8]};
        end
    end

    assign word_valid = byte_valid && !clr && (cnt_q == CNT_W'(HDR_BYTES - 1));
    assign word       = {byte_data, shift_q};

    // Byte counter and partial-word storage.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            shift_q <= '0;
        end else begin
            cnt_q   <= cnt_d;
            shift_q <= shift_d;
        end
    end
endmodule

// File: rtl/imem_stream_loader.sv
// Instruction-memory program loader: parses [N][N words][checksum] from a
// byte stream, writes the words to imem and holds the core in reset until
// RST_HOLD cycles after the last write.
// Optional checksum field and 32-bit word sum: define IMEM_LOADER_CHECKSUM_EN.
module imem_stream_loader
    import imem_loader_pkg::*;
#(
    parameter int IMEM_DEPTH = 1024,
    parameter int ADDR_W     = $clog2(IMEM_DEPTH),
    parameter int RST_HOLD   = 10
) (
    input  logic                clk,
    input  logic                rst,
    imem_stream_loader_if.slave bus
);
    localparam int                 HOLD_W    = (RST_HOLD > 1) ? $clog2(RST_HOLD) : 1;
    localparam logic [HOLD_W-1:0]  HOLD_INIT = HOLD_W'(RST_HOLD - 1);
    localparam logic [ADDR_W:0]    IDX_ONE   = (ADDR_W + 1)'(1);
    localparam logic [INSTR_W-1:0] DEPTH_W   = INSTR_W'(IMEM_DEPTH);

    loader_state_t      state_q, state_d;
    logic [ADDR_W:0]    word_idx_q, word_idx_d;   // one extra bit so N = IMEM_DEPTH fits
    logic [ADDR_W:0]    n_q, n_d;
    logic [HOLD_W-1:0]  hold_q, hold_d;
    logic               we_q, we_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [INSTR_W-1:0] wdata_q, wdata_d;
    logic               core_rst_q, core_rst_d;
    logic               done_q, done_d;
    logic               err_q, err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [INSTR_W-1:0] csum_q, csum_d;
`endif

    logic               in_ready;
    logic               accept;
    logic               word_valid;
    logic [INSTR_W-1:0] word;

    // Ready is purely a function of state so a byte is never half-accepted.
    assign in_ready = (state_q == S_LEN) || (state_q == S_LOAD) || (state_q == S_CSUM);
    assign accept   = bus.in_valid && in_ready;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr        (!in_ready),
        .byte_valid (accept),
        .byte_data  (bus.in_data),
        .word_valid (word_valid),
        .word       (word)
    );

    // Next-state, write-port and status decode.
    always_comb begin
        state_d    = state_q;
        word_idx_d = word_idx_q;
        n_d        = n_q;
        hold_d     = hold_q;
        we_d       = 1'b0;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        csum_d     = csum_q;
`endif
        case (state_q)
            S_LEN: begin
                if (word_valid) begin
                    if (word > DEPTH_W) begin
                        state_d = S_ERR;
                    end else if (word == '0) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_HOLD;
                        hold_d  = HOLD_INIT;
`endif
                    end else begin
                        state_d = S_LOAD;
                        n_d     = word[ADDR_W:0];
                    end
                end
            end
            S_LOAD: begin
                if (word_valid) begin
                    we_d       = 1'b1;
                    addr_d     = word_idx_q[ADDR_W-1:0];
                    wdata_d    = word;
                    word_idx_d = word_idx_q + IDX_ONE;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    csum_d     = csum_q + word;
`endif
                    if (word_idx_q == n_q - IDX_ONE) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                        state_d = S_CSUM;
`else
                        state_d = S_HOLD;
                        hold_d  = HOLD_INIT;
`endif
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            S_CSUM: begin
                if (word_valid) begin
                    if (word == csum_q) begin
                        state_d = S_HOLD;
                        hold_d  = HOLD_INIT;
                    end else begin
                        state_d = S_ERR;
                    end
                end
            end
`endif
            S_HOLD: begin
                if (hold_q == '0) begin
                    state_d = S_RUN;
                end else begin
                    hold_d = hold_q - HOLD_W'(1);
                end
            end
            S_RUN:   state_d = S_RUN;
            S_ERR:   state_d = S_ERR;
            default: state_d = S_ERR;
        endcase

        core_rst_d = (state_d != S_RUN);
        done_d     = (state_d == S_RUN);
        err_d      = (state_d == S_ERR);
    end

    // State and registered outputs; rst returns everything to the idle image-load point.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LEN;
            word_idx_q <= '0;
            n_q        <= '0;
            hold_q     <= '0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= '0;
`endif
        end else begin
            state_q    <= state_d;
            word_idx_q <= word_idx_d;
            n_q        <= n_d;
            hold_q     <= hold_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            csum_q     <= csum_d;
`endif
        end
    end

    assign bus.in_ready   = in_ready;
    assign bus.imem_we    = we_q;
    assign bus.imem_addr  = addr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_stream_loader.sv
// Scoreboard bench for imem_stream_loader: stimulus builds byte images, a
// stream-level model predicts writes/outcome/release cycle, a negedge monitor
// compares every imem write and the core_rst release against the model.
module tb_imem_stream_loader;
    localparam int DEPTH    = 1024;
    localparam int AW       = 10;
    localparam int RST_HOLD = 10;

    typedef struct {
        logic [AW-1:0] addr;
        logic [31:0]   data;
    } wr_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_stream_loader_if #(.ADDR_W(AW)) bus();

    imem_stream_loader #(
        .IMEM_DEPTH (DEPTH),
        .ADDR_W     (AW),
        .RST_HOLD   (RST_HOLD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int          checks = 0;
    int          errors = 0;
    int          cyc = 0;
    logic [7:0]  stim_q[$];
    logic [31:0] word_q[$];
    wr_t         exp_q[$];
    int          exp_release = -1;
    int          exp_consumed = 0;
    int          exp_final = -1;
    int          exp_outcome = 0;   // 0: incomplete, 1: run, 2: error
    logic        prev_core_rst = 1'b1;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Monitor: pops an expected write for every imem_we and checks release timing.
    always @(negedge clk) begin
        if (rst) begin
            prev_core_rst <= 1'b1;
        end else begin
            if (bus.imem_we) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_write: got addr %h data %h expected none", bus.imem_addr, bus.imem_wdata);
                end else begin
                    chk("write_addr", 32'(bus.imem_addr), 32'(exp_q[0].addr));
                    chk("write_data", bus.imem_wdata, exp_q[0].data);
                    exp_q.delete(0);
                end
            end
            if (prev_core_rst && !bus.core_rst) begin
                if (exp_release < 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_release: got release at cycle %0d expected none", cyc);
                end else begin
                    chk("release_cycle", 32'(cyc), 32'(exp_release));
                end
            end
            prev_core_rst <= bus.core_rst;
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic push_le(input logic [31:0] w);
        for (int b = 0; b < 4; b++) stim_q.push_back(w[8*b +: 8]);
    endtask

    // Builds [N][words][checksum+delta] from word_q.
    task automatic build_image(input logic [31:0] n_field, input logic [31:0] csum_delta);
        logic [31:0] s;
        s = 32'h0;
        stim_q.delete();
        push_le(n_field);
        foreach (word_q[k]) begin
            push_le(word_q[k]);
            s = s + word_q[k];
        end
`ifdef IMEM_LOADER_CHECKSUM_EN
        push_le(s + csum_delta);
`else
        if (csum_delta != 0 && s == 0) $display("note: checksum delta unused");
`endif
    endtask

    // Stream-level model: parses stim_q per the format rules.
    task automatic model_stream();
        int unsigned n;
        int          total;
        int          sz;
        logic [31:0] w;
        logic [31:0] sum;
        sz = stim_q.size();
        n = {stim_q[3], stim_q[2], stim_q[1], stim_q[0]};
        exp_final   = -1;
        exp_outcome = 0;
        if (n > 32'(DEPTH)) begin
            exp_consumed = 4;
            exp_outcome  = 2;
        end else begin
            total = 4 + 4 * int'(n);
`ifdef IMEM_LOADER_CHECKSUM_EN
            total = total + 4;
`endif
            exp_consumed = (sz < total) ? sz : total;
            sum = 32'h0;
            for (int k = 0; k < int'(n); k++) begin
                if (4 + 4 * k + 3 < sz) begin
                    w = {stim_q[4+4*k+3], stim_q[4+4*k+2], stim_q[4+4*k+1], stim_q[4+4*k]};
                    exp_q.push_back('{addr: AW'(k), data: w});
                    sum = sum + w;
                end
            end
            if (sz >= total) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                w = {stim_q[total-1], stim_q[total-2], stim_q[total-3], stim_q[total-4]};
                if (w == sum) begin
                    exp_outcome = 1;
                    exp_final   = total - 1;
                end else begin
                    exp_outcome = 2;
                end
`else
                exp_outcome = 1;
                exp_final   = total - 1;
`endif
            end
        end
    endtask

    // mode 0: back-to-back, 1: valid one cycle in three, 2: random gaps.
    task automatic send_stream(input int mode);
        int gaps;
        for (int i = 0; i < stim_q.size(); i++) begin
            gaps = (mode == 0) ? 0 : (mode == 1) ? 2 : int'($urandom_range(0, 3));
            repeat (gaps) begin
                @(negedge clk);
                bus.in_valid = 1'b0;
                bus.in_data  = 8'($urandom);
            end
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_data  = stim_q[i];
            #1;
            chk("in_ready", 32'(bus.in_ready), (i < exp_consumed) ? 32'd1 : 32'd0);
            if (i == exp_final) exp_release = cyc + 1 + RST_HOLD;
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        exp_q.delete();
        exp_release  = -1;
        #1;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
        chk("rst_imem_we",  32'(bus.imem_we), 32'd0);
        chk("rst_addr",     32'(bus.imem_addr), 32'd0);
        chk("rst_wdata",    bus.imem_wdata, 32'd0);
        chk("rst_core_rst", 32'(bus.core_rst), 32'd1);
        chk("rst_done",     32'(bus.done), 32'd0);
        chk("rst_err",      32'(bus.err), 32'd0);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic run_case(input string name, input int mode);
        model_stream();
        $display("case %s bytes=%0d writes=%0d outcome=%0d mode=%0d",
                 name, stim_q.size(), exp_q.size(), exp_outcome, mode);
        send_stream(mode);
        if (exp_outcome == 1) begin
            for (int t = 0; t < RST_HOLD + 20 && !bus.done; t++) @(negedge clk);
            repeat (3) @(negedge clk);
            chk({name, "_done"},     32'(bus.done), 32'd1);
            chk({name, "_core_rst"}, 32'(bus.core_rst), 32'd0);
            chk({name, "_err"},      32'(bus.err), 32'd0);
        end else if (exp_outcome == 2) begin
            repeat (3) @(negedge clk);
            chk({name, "_err"},      32'(bus.err), 32'd1);
            chk({name, "_core_rst"}, 32'(bus.core_rst), 32'd1);
            chk({name, "_done"},     32'(bus.done), 32'd0);
            chk({name, "_in_ready"}, 32'(bus.in_ready), 32'd0);
        end
        chk({name, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        apply_reset();
        word_q = '{32'h00500093, 32'h00A00113};
        build_image(32'd2, 32'd0);
        run_case("n2_b2b", 0);

        apply_reset();
        build_image(32'd2, 32'd0);
        run_case("n2_every3", 1);

        apply_reset();
        word_q = {};
        build_image(32'd0, 32'd0);
        run_case("n0", 0);

        apply_reset();
        word_q = {};
        build_image(32'd1025, 32'd0);
        repeat (50) stim_q.push_back(8'($urandom));
        run_case("n1025", 0);

        apply_reset();
        word_q = {};
        build_image(32'hFFFF_0001, 32'd0);
        repeat (12) stim_q.push_back(8'($urandom));
        run_case("n_huge", 2);

        // Partial image interrupted by reset, then the full image.
        apply_reset();
        word_q = '{32'h00500093, 32'h00A00113};
        build_image(32'd2, 32'd0);
        while (stim_q.size() > 6) void'(stim_q.pop_back());
        run_case("n2_partial", 0);
        apply_reset();
        build_image(32'd2, 32'd0);
        run_case("n2_after_rst", 0);

        apply_reset();
        word_q = {};
        for (int k = 0; k < DEPTH; k++) word_q.push_back($urandom);
        build_image(32'(DEPTH), 32'd0);
        run_case("n_depth", 0);

        for (int r = 0; r < 6; r++) begin
            apply_reset();
            word_q = {};
            n = int'($urandom_range(1, 12));
            for (int k = 0; k < n; k++) word_q.push_back($urandom);
            build_image(32'(n), 32'd0);
            run_case("random", int'($urandom_range(0, 2)));
        end

`ifdef IMEM_LOADER_CHECKSUM_EN
        apply_reset();
        word_q = '{32'h00000013};
        build_image(32'd1, 32'd0);
        run_case("csum_ok", 0);

        apply_reset();
        build_image(32'd1, 32'd1);
        run_case("csum_bad", 0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
